// File: rtl/instr_encoder_if.sv
// Handshake/bus bundle for instr_encoder: field-set input side, packed-word
// output side and status.
// slave modport belongs to the encoder; master to the sequencer/core side.
interface instr_encoder_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [4:0]               in_op;
    logic [4:0]               in_rdst;
    logic [4:0]               in_rsrc1;
    logic                     in_imm_mode;
    logic [4:0]               in_rsrc2;
    logic [15:0]              in_imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_ir;
    logic                     err_illegal;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [CNT_W-1:0]         issue_count;

    modport master (
        output in_valid, in_op, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_ir, err_illegal, fifo_level, issue_count
    );

    modport slave (
        input  in_valid, in_op, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_ir, err_illegal, fifo_level, issue_count
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit IR words and
// buffers them in a first-word-fall-through FIFO toward the core.
// Optional feature macro: INSTR_ENC_MUL_HI_EN -- each accepted mul also
// enqueues a movsgpr to rdst+1 so the SGPR high half is captured.
module instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    instr_encoder_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

`ifdef INSTR_ENC_MUL_HI_EN
    localparam int unsigned HEADROOM = 2;
`else
    localparam int unsigned HEADROOM = 1;
`endif
    localparam logic [LW-1:0] READY_MAX = LW'(DEPTH - HEADROOM);

    typedef enum logic [4:0] {
        OP_MOVSGPR = 5'd0,
        OP_MOV     = 5'd1,
        OP_ADD     = 5'd2,
        OP_SUB     = 5'd3,
        OP_MUL     = 5'd4,
        OP_AND     = 5'd5,
        OP_OR      = 5'd6,
        OP_XOR     = 5'd7,
        OP_LOAD    = 5'd8,
        OP_STORE   = 5'd9
    } opcode_e;

    logic [31:0]      mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic [LW-1:0]    push_n;
    logic [CNT_W-1:0] count;
    logic             err_q;
    logic             ready;
    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;
    logic [31:0]      word;
`ifdef INSTR_ENC_MUL_HI_EN
    logic             push_two;
    logic [31:0]      hi_word;
`endif

    assign ready  = (level <= READY_MAX);
    assign accept = bus.in_valid && ready;
    assign legal  = (bus.in_op <= OP_STORE);
    assign push   = accept && legal;
    assign pop    = (level != '0) && bus.out_ready;

    assign bus.in_ready    = ready;
    assign bus.out_valid   = (level != '0);
    assign bus.out_ir      = (level != '0) ? mem[rd_ptr] : '0;
    assign bus.err_illegal = err_q;
    assign bus.fifo_level  = level;
    assign bus.issue_count = count;

    // Field packing; movsgpr keeps only op and rdst, everything below is zero.
    always_comb begin
        word        = '0;
        word[31:27] = bus.in_op;
        word[26:22] = bus.in_rdst;
        if (bus.in_op != OP_MOVSGPR) begin
            word[21:17] = bus.in_rsrc1;
            word[16]    = bus.in_imm_mode;
            if (bus.in_imm_mode) begin
                word[15:0] = bus.in_imm;
            end else begin
                word[15:11] = bus.in_rsrc2;
            end
        end
    end

    // Number of entries written this cycle and the resulting occupancy.
    always_comb begin
`ifdef INSTR_ENC_MUL_HI_EN
        push_two = push && (bus.in_op == OP_MUL);
        hi_word  = {OP_MOVSGPR, bus.in_rdst + 5'd1, 22'h0};
        push_n   = push_two ? LW'(2) : LW'(push);
`else
        push_n   = LW'(push);
`endif
        level_next = level + push_n - LW'(pop);
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
`ifdef INSTR_ENC_MUL_HI_EN
            if (push_two) begin
                mem[wr_ptr + PW'(1)] <= hi_word;
            end
`endif
        end
    end

    // Pointers, occupancy, issue counter and illegal-op pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                count  <= count + CNT_W'(1);
            end
            level <= level_next;
            err_q <= accept && !legal;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model plus
// directed vectors with hand-computed words.
module tb_instr_encoder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;
`ifdef INSTR_ENC_MUL_HI_EN
    localparam int unsigned HEAD = 2;
`else
    localparam int unsigned HEAD = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] q[$];
    int          m_cnt = 0;
    bit          m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word value built from field weights.
    function automatic logic [31:0] pack(input int unsigned op, input int unsigned rdst,
                                         input int unsigned rs1, input int unsigned immm,
                                         input int unsigned rs2, input int unsigned imm);
        int unsigned w;
        w = op * (2 ** 27) + rdst * (2 ** 22);
        if (op != 0) begin
            w += rs1 * (2 ** 17) + immm * (2 ** 16);
            w += (immm != 0) ? imm : rs2 * (2 ** 11);
        end
        return 32'(w);
    endfunction

    // Reference model: updates on each rising edge from the inputs presented.
    always @(posedge clk) begin : model
        int unsigned lvl;
        bit rdy;
        bit pop;
        bit acc;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            lvl   = q.size();
            rdy   = (lvl <= DEPTH - HEAD);
            pop   = (lvl != 0) && bus.out_ready;
            acc   = bus.in_valid && rdy;
            m_err = acc && (bus.in_op > 9);
            if (pop) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (acc && bus.in_op <= 9) begin
                q.push_back(pack(bus.in_op, bus.in_rdst, bus.in_rsrc1, bus.in_imm_mode,
                                 bus.in_rsrc2, bus.in_imm));
`ifdef INSTR_ENC_MUL_HI_EN
                if (bus.in_op == 5'd4) q.push_back(pack(0, (bus.in_rdst + 1) % 32, 0, 0, 0, 0));
`endif
            end
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", bus.out_valid, q.size() != 0);
            check("out_ir", bus.out_ir, (q.size() != 0) ? q[0] : 32'h0);
            check("fifo_level", bus.fifo_level, q.size());
            check("issue_count", bus.issue_count, m_cnt % (1 << CNT_W));
            check("in_ready", bus.in_ready, q.size() <= DEPTH - HEAD);
            check("err_illegal", bus.err_illegal, m_err);
        end
    end

    task automatic drive(input logic [4:0] op, input logic [4:0] rdst, input logic [4:0] rs1,
                         input logic immm, input logic [4:0] rs2, input logic [15:0] imm);
        bus.in_op       = op;
        bus.in_rdst     = rdst;
        bus.in_rsrc1    = rs1;
        bus.in_imm_mode = immm;
        bus.in_rsrc2    = rs2;
        bus.in_imm      = imm;
    endtask

    task automatic push(input logic [4:0] op, input logic [4:0] rdst, input logic [4:0] rs1,
                        input logic immm, input logic [4:0] rs2, input logic [15:0] imm);
        drive(op, rdst, rs1, immm, rs2, imm);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_level", bus.fifo_level, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_ir", bus.out_ir, 0);
        check("rst_count", bus.issue_count, 0);
        check("rst_err", bus.err_illegal, 0);
        rst_n = 1'b1;

        // add immediate
        push(5'd2, 5'd1, 5'd2, 1'b1, 5'd0, 16'h0005);
        check("t1_ir", bus.out_ir, 32'h1045_0005);
        check("t1_level", bus.fifo_level, 1);
        drain(1);
        check("t1_count", bus.issue_count, 1);

        // sub register: immediate field ignored
        push(5'd3, 5'd3, 5'd4, 1'b0, 5'd5, 16'hFFFF);
        check("t2_ir", bus.out_ir, 32'h18C8_2800);
        drain(1);

        // movsgpr clears everything below rdst
        push(5'd0, 5'd7, 5'd9, 1'b1, 5'd3, 16'hABCD);
        check("movsgpr_ir", bus.out_ir, 32'h01C0_0000);
        drain(1);

        // fill to full, hold a fifth, then drain in order
        for (int i = 0; i < 4; i++) push(5'(5 + i), 5'(i), 5'(i + 10), 1'b1, 5'd0, 16'(16'h1111 * (i + 1)));
`ifndef INSTR_ENC_MUL_HI_EN
        check("full_level", bus.fifo_level, 4);
        check("full_ready", bus.in_ready, 0);
`endif
        drive(5'd9, 5'd30, 5'd29, 1'b1, 5'd0, 16'hDEAD);
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
`ifndef INSTR_ENC_MUL_HI_EN
        check("first_pop_ready", bus.in_ready, 1);
`endif
        drain(4);
        check("drained_level", bus.fifo_level, 0);
`ifndef INSTR_ENC_MUL_HI_EN
        check("drained_count", bus.issue_count, 7);
`endif

        // streaming push+pop, crossing the issue_count wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(5'(i % 10), 5'(i), 5'(31 - i), 1'(i % 2), 5'(i + 3), 16'(i * 257));
        drain(8);

        // illegal opcodes
        push(5'd1, 5'd2, 5'd3, 1'b1, 5'd0, 16'h0042);
        push(5'b01010, 5'd1, 5'd1, 1'b1, 5'd0, 16'h0001);
        check("t4_err", bus.err_illegal, 1);
        check("t4_level", bus.fifo_level, 1);
        check("t4_valid", bus.out_valid, 1);
        @(negedge clk);
        check("t4_err_drop", bus.err_illegal, 0);
        push(5'd31, 5'd1, 5'd1, 1'b0, 5'd1, 16'h0);
        check("t4_err31", bus.err_illegal, 1);

        // reset mid-operation
        push(5'd6, 5'd4, 5'd5, 1'b0, 5'd6, 16'h0);
        push(5'd7, 5'd8, 5'd9, 1'b1, 5'd0, 16'h7777);
        check("t5_level3", bus.fifo_level, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_valid", bus.out_valid, 0);
        check("t5_ir", bus.out_ir, 0);
        check("t5_level", bus.fifo_level, 0);
        check("t5_count", bus.issue_count, 0);

`ifdef INSTR_ENC_MUL_HI_EN
        // mul also enqueues movsgpr to rdst+1 (wrapping to 0)
        push(5'd4, 5'd31, 5'd1, 1'b0, 5'd2, 16'h0);
        check("t6_level", bus.fifo_level, 2);
        check("t6_ir_mul", bus.out_ir, 32'h27C2_1000);
        drain(1);
        check("t6_ir_hi", bus.out_ir, 32'h0000_0000);
        check("t6_valid", bus.out_valid, 1);
        push(5'd1, 5'd1, 5'd1, 1'b1, 5'd0, 16'h1);
        push(5'd1, 5'd2, 5'd2, 1'b1, 5'd0, 16'h2);
        check("t6_level3", bus.fifo_level, 3);
        check("t6_ready", bus.in_ready, 0);
`endif

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
